// File: rtl/hcu_round_ctrl.sv
// Block sequencer for the hash computation unit: INIT -> LOAD -> ROUND x N -> UPDATE -> (DONE | IDLE).
// Every output is a flop loaded from next-state, so nothing combinational reaches the outputs from the inputs.
module hcu_round_ctrl #(
   parameter int ROUNDS_256 = 64,
   parameter int ROUNDS_512 = 80
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] sha_type,
   input  logic       msg_valid,
   input  logic       msg_first,
   input  logic       msg_last,
   output logic       msg_ready,
   output logic [1:0] sha_type_q,
   output logic       hash_init,
   output logic       core_load,
   output logic       round_en,
   output logic       wt_load,
   output logic [6:0] round_idx,
   output logic       hash_update,
   output logic       digest_valid,
   input  logic       digest_ack,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_LOAD, S_ROUND, S_UPDATE, S_DONE
   } state_t;

   localparam logic [6:0] LAST_256 = 7'(ROUNDS_256 - 1);
   localparam logic [6:0] LAST_512 = 7'(ROUNDS_512 - 1);

   state_t     state_q, state_d;
   logic [6:0] round_q, round_d;
   logic [1:0] sha_q, sha_d;
   logic       in_msg_q, in_msg_d;
   logic       last_q, last_d;
   logic       ready_q;
   logic       init_q, load_q, ren_q, wt_q, upd_q, dv_q, busy_q;
   logic [6:0] last_idx;

   assign last_idx = sha_q[1] ? LAST_512 : LAST_256;

   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      sha_d    = sha_q;
      in_msg_d = in_msg_q;
      last_d   = last_q;
      case (state_q)
         S_IDLE: begin
            if (msg_valid && ready_q) begin
               last_d = msg_last;
               // A first flag, or any block arriving outside a message, (re)starts from the initial hash.
               if (msg_first || !in_msg_q) begin
                  sha_d    = sha_type;
                  in_msg_d = 1'b1;
                  state_d  = S_INIT;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_INIT: state_d = S_LOAD;
         S_LOAD: begin
            round_d = 7'd0;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            if (round_q == last_idx) begin
               state_d = S_UPDATE;
            end else begin
               round_d = round_q + 7'd1;
            end
         end
         S_UPDATE: begin
            if (last_q) begin
               in_msg_d = 1'b0;
               state_d  = S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DONE: begin
            if (digest_ack) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         round_q  <= 7'd0;
         sha_q    <= 2'b00;
         in_msg_q <= 1'b0;
         last_q   <= 1'b0;
         ready_q  <= 1'b0;
         init_q   <= 1'b0;
         load_q   <= 1'b0;
         ren_q    <= 1'b0;
         wt_q     <= 1'b0;
         upd_q    <= 1'b0;
         dv_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         round_q  <= round_d;
         sha_q    <= sha_d;
         in_msg_q <= in_msg_d;
         last_q   <= last_d;
         ready_q  <= (state_d == S_IDLE);
         init_q   <= (state_d == S_INIT);
         load_q   <= (state_d == S_LOAD);
         ren_q    <= (state_d == S_ROUND);
         wt_q     <= (state_d == S_ROUND) && (round_d < 7'd16);
         upd_q    <= (state_d == S_UPDATE);
         dv_q     <= (state_d == S_DONE);
         busy_q   <= (state_d != S_IDLE);
      end
   end

   assign msg_ready    = ready_q;
   assign sha_type_q   = sha_q;
   assign hash_init    = init_q;
   assign core_load    = load_q;
   assign round_en     = ren_q;
   assign wt_load      = wt_q;
   assign round_idx    = round_q;
   assign hash_update  = upd_q;
   assign digest_valid = dv_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_hcu_round_ctrl.sv
// Directed bench for hcu_round_ctrl: per-cycle strobe timeline checks against a cycle-number model.
module tb_hcu_round_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] sha_type = 2'b00;
   logic       msg_valid = 1'b0, msg_first = 1'b0, msg_last = 1'b0, digest_ack = 1'b0;
   logic       msg_ready, hash_init, core_load, round_en, wt_load, hash_update, digest_valid, busy;
   logic [1:0] sha_type_q;
   logic [6:0] round_idx;

   int vecs = 0;
   int errs = 0;

   hcu_round_ctrl #(.ROUNDS_256(64), .ROUNDS_512(80)) dut (
      .clk(clk), .reset(reset), .sha_type(sha_type),
      .msg_valid(msg_valid), .msg_first(msg_first), .msg_last(msg_last),
      .msg_ready(msg_ready), .sha_type_q(sha_type_q), .hash_init(hash_init),
      .core_load(core_load), .round_en(round_en), .wt_load(wt_load),
      .round_idx(round_idx), .hash_update(hash_update), .digest_valid(digest_valid),
      .digest_ack(digest_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   wire [7:0] obs = {msg_ready, hash_init, core_load, round_en, wt_load, hash_update, digest_valid, busy};

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Expected {ready,init,load,round_en,wt_load,update,digest_valid,busy} at cycle c after accept.
   function automatic logic [7:0] exp_vec(int c, bit first, bit last, int n);
      int off;
      logic [7:0] v;
      logic ren;
      off  = first ? 3 : 2;
      ren  = (c >= off) && (c < off + n);
      v[7] = !last && (c == off + n + 1);
      v[6] = first && (c == 1);
      v[5] = (c == off - 1);
      v[4] = ren;
      v[3] = ren && ((c - off) < 16);
      v[2] = (c == off + n);
      v[1] = last && (c == off + n + 1);
      v[0] = !v[7];
      return v;
   endfunction

   task automatic send(input bit first, input bit last, input logic [1:0] t);
      msg_valid = 1'b1; msg_first = first; msg_last = last; sha_type = t;
      step;
      msg_valid = 1'b0; msg_first = 1'b0; msg_last = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2;
      vecs++;
      if (obs !== 8'h00 || round_idx !== 7'd0 || sha_type_q !== 2'b00) begin
         errs++;
         $display("FAIL reset_state: obs=%b idx=%0d type=%b, want 00000000/0/00", obs, round_idx, sha_type_q);
      end
      @(negedge clk);
      reset = 1'b0;
      step;
      vecs++;
      if (obs !== 8'b1000_0000) begin
         errs++;
         $display("FAIL reset_release: obs=%b want 10000000", obs);
      end
   endtask

   task automatic test_sha256_single;
      logic [7:0] e;
      vecs++;
      if (msg_ready !== 1'b1) begin errs++; $display("FAIL s256_ready0: got %b want 1", msg_ready); end
      send(1'b1, 1'b1, 2'b01);
      for (int c = 1; c <= 68; c++) begin
         if (c > 1) step;
         e = exp_vec(c, 1'b1, 1'b1, 64);
         vecs++;
         if (obs !== e) begin errs++; $display("FAIL s256_c%0d: obs=%b want %b", c, obs, e); end
         if (e[4] || e[2]) begin
            vecs++;
            if (round_idx !== (e[2] ? 7'd63 : 7'(c - 3))) begin
               errs++; $display("FAIL s256_idx_c%0d: got %0d", c, round_idx);
            end
         end
      end
      digest_ack = 1'b1;
      step;
      digest_ack = 1'b0;
      vecs++;
      if (obs !== 8'b1000_0000) begin errs++; $display("FAIL s256_ack: obs=%b want 10000000", obs); end
   endtask

   task automatic test_digest_hold;
      logic [7:0] e;
      send(1'b1, 1'b1, 2'b01);
      for (int c = 1; c <= 68; c++) begin
         if (c > 1) step;
         e = exp_vec(c, 1'b1, 1'b1, 64);
         vecs++;
         if (obs !== e) begin errs++; $display("FAIL hold_c%0d: obs=%b want %b", c, obs, e); end
      end
      for (int i = 0; i < 10; i++) begin
         msg_valid = 1'b1; msg_first = 1'b1;
         step;
         vecs++;
         if (obs !== 8'b0000_0011) begin errs++; $display("FAIL hold_wait%0d: obs=%b want 00000011", i, obs); end
      end
      msg_valid = 1'b0; msg_first = 1'b0;
      digest_ack = 1'b1;
      step;
      digest_ack = 1'b0;
      vecs++;
      if (obs !== 8'b1000_0000) begin errs++; $display("FAIL hold_ack: obs=%b want 10000000", obs); end
   endtask

   task automatic test_sha512_two_block;
      logic [7:0] e;
      bit first;
      for (int b = 0; b < 2; b++) begin
         first = (b == 0);
         if (first) send(1'b1, 1'b0, 2'b11);
         else       send(1'b0, 1'b1, 2'b10);
         for (int c = 1; c <= (first ? 84 : 83); c++) begin
            if (c > 1) step;
            e = exp_vec(c, first, !first, 80);
            vecs++;
            if (obs !== e) begin errs++; $display("FAIL s512_b%0d_c%0d: obs=%b want %b", b, c, obs, e); end
            if (e[2]) begin
               vecs++;
               if (round_idx !== 7'd79) begin errs++; $display("FAIL s512_idx_b%0d: got %0d want 79", b, round_idx); end
            end
         end
         vecs++;
         if (sha_type_q !== 2'b11) begin errs++; $display("FAIL s512_type_b%0d: got %b want 11", b, sha_type_q); end
      end
      digest_ack = 1'b1;
      step;
      digest_ack = 1'b0;
      vecs++;
      if (obs !== 8'b1000_0000) begin errs++; $display("FAIL s512_ack: obs=%b want 10000000", obs); end
   endtask

   task automatic test_reset_mid_round;
      logic [7:0] e;
      send(1'b1, 1'b1, 2'b00);
      for (int c = 1; c <= 33; c++) begin
         if (c > 1) step;
         e = exp_vec(c, 1'b1, 1'b1, 64);
         vecs++;
         if (obs !== e) begin errs++; $display("FAIL rst_pre_c%0d: obs=%b want %b", c, obs, e); end
      end
      vecs++;
      if (round_idx !== 7'd30) begin errs++; $display("FAIL rst_idx30: got %0d want 30", round_idx); end
      #1 reset = 1'b1;
      #1;
      vecs++;
      if (obs !== 8'h00 || round_idx !== 7'd0 || sha_type_q !== 2'b00) begin
         errs++; $display("FAIL rst_async: obs=%b idx=%0d type=%b want 0/0/00", obs, round_idx, sha_type_q);
      end
      step;
      vecs++;
      if (obs !== 8'h00) begin errs++; $display("FAIL rst_held: obs=%b want 00000000", obs); end
      reset = 1'b0;
      step;
      vecs++;
      if (obs !== 8'b1000_0000) begin errs++; $display("FAIL rst_rel: obs=%b want 10000000", obs); end
      send(1'b1, 1'b1, 2'b00);
      for (int c = 1; c <= 68; c++) begin
         if (c > 1) step;
         e = exp_vec(c, 1'b1, 1'b1, 64);
         vecs++;
         if (obs !== e) begin errs++; $display("FAIL s224_c%0d: obs=%b want %b", c, obs, e); end
      end
      vecs++;
      if (sha_type_q !== 2'b00) begin errs++; $display("FAIL s224_type: got %b want 00", sha_type_q); end
      digest_ack = 1'b1;
      step;
      digest_ack = 1'b0;
   endtask

   task automatic test_nonfirst_no_msg;
      logic [7:0] e;
      send(1'b0, 1'b0, 2'b11);
      for (int c = 1; c <= 84; c++) begin
         if (c > 1) step;
         e = exp_vec(c, 1'b1, 1'b0, 80);
         vecs++;
         if (obs !== e) begin errs++; $display("FAIL nofirst_c%0d: obs=%b want %b", c, obs, e); end
      end
      vecs++;
      if (sha_type_q !== 2'b11) begin errs++; $display("FAIL nofirst_type: got %b want 11", sha_type_q); end
      // first flag inside an open message restarts it with a new type
      send(1'b1, 1'b1, 2'b01);
      for (int c = 1; c <= 68; c++) begin
         if (c > 1) step;
         e = exp_vec(c, 1'b1, 1'b1, 64);
         vecs++;
         if (obs !== e) begin errs++; $display("FAIL restart_c%0d: obs=%b want %b", c, obs, e); end
      end
      vecs++;
      if (sha_type_q !== 2'b01) begin errs++; $display("FAIL restart_type: got %b want 01", sha_type_q); end
      digest_ack = 1'b1;
      step;
      digest_ack = 1'b0;
   endtask

   initial begin
      test_reset;
      test_sha256_single;
      test_digest_hold;
      test_sha512_two_block;
      test_reset_mid_round;
      test_nonfirst_no_msg;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
